// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU: opcodes, FSM state encodings,
// fault codes and the default block-op XOR key.
package cpu_pkg;

   localparam logic [4:0] OP_ADD    = 5'h00;
   localparam logic [4:0] OP_SUB    = 5'h01;
   localparam logic [4:0] OP_AND    = 5'h02;
   localparam logic [4:0] OP_OR     = 5'h03;
   localparam logic [4:0] OP_XOR    = 5'h04;
   localparam logic [4:0] OP_NOT    = 5'h05;
   localparam logic [4:0] OP_SHL    = 5'h06;
   localparam logic [4:0] OP_LDI    = 5'h07;
   localparam logic [4:0] OP_LD     = 5'h08;
   localparam logic [4:0] OP_ST     = 5'h09;
   localparam logic [4:0] OP_JMP    = 5'h0A;
   localparam logic [4:0] OP_JEQ    = 5'h0B;
   localparam logic [4:0] OP_JNE    = 5'h0C;
   localparam logic [4:0] OP_CALL   = 5'h0D;
   localparam logic [4:0] OP_RET    = 5'h0E;
   localparam logic [4:0] OP_BINC   = 5'h0F;
   localparam logic [4:0] OP_BENC   = 5'h10;
   localparam logic [4:0] OP_BDEC   = 5'h11;
   localparam logic [4:0] OP_SETKEY = 5'h12;
   localparam logic [4:0] OP_HALT   = 5'h1F;

   // FSM state encodings
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_EXEC   = 3'd1;
   localparam logic [2:0] ST_LDWAIT = 3'd2;
   localparam logic [2:0] ST_BLK_RD = 3'd3;
   localparam logic [2:0] ST_BLK_WR = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;
   localparam logic [2:0] ST_FAULT  = 3'd6;

   localparam logic [1:0] FAULT_NONE = 2'b00;
   localparam logic [1:0] FAULT_OVF  = 2'b01;
   localparam logic [1:0] FAULT_UDF  = 2'b10;

   localparam logic [18:0] CPU_KEY_DEFAULT = 19'h1999F;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for register-register ops 00-06 plus the JEQ/JNE
// equality compare.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 19
)(
   input  logic [4:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] cmp_a,
   input  logic [DATA_W-1:0] cmp_b,
   output logic [DATA_W-1:0] y,
   output logic              eq
);

   // Arithmetic/logic result select
   always_comb begin
      y = {DATA_W{1'b0}};
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOT:  y = ~a;
         OP_SHL:  y = {a[DATA_W-2:0], 1'b0};
         default: y = {DATA_W{1'b0}};
      endcase
   end

   assign eq = (cmp_a == cmp_b);

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: fetch handshake, register file, call stack, data memory
// and block ops. Define CPU_KEY_REG_EN to add the SETKEY-loadable key register.
module cpu_core_mc
   import cpu_pkg::*;
#(
   parameter int                DATA_W      = 19,
   parameter int                REG_AW      = 4,
   parameter int                STACK_DEPTH = 16,
   parameter int                DMEM_AW     = 10,
   parameter int                BLK_LEN     = 8,
   parameter logic [DATA_W-1:0] KEY_DEFAULT = DATA_W'(CPU_KEY_DEFAULT)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              halted,
   output logic              fault,
   output logic [1:0]        fault_code
);

   localparam int LDI_W  = DATA_W - 5 - REG_AW;
   localparam int SP_W   = $clog2(STACK_DEPTH + 1);
   localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CNT_W  = $clog2(BLK_LEN) + 1;
   localparam int DEPTH  = 2 ** DMEM_AW;

   logic [2:0]         state_r, state_s;
   logic [DATA_W-1:0]  pc_r, pc_s, pc_inc_s;
   logic [DATA_W-1:0]  instr_r;
   logic [4:0]         opcode_s;
   logic [REG_AW-1:0]  r1_s, r2_s, r3_s;
   logic [DATA_W-1:0]  imm_s, ldi_s;
   logic [DATA_W-1:0]  rf_r [2**REG_AW];
   logic [DATA_W-1:0]  v1_s, v2_s, v3_s;
   logic [DATA_W-1:0]  stack_r [STACK_DEPTH];
   logic [SP_W-1:0]    sp_r, sp_s, sp_dec_s;
   logic               push_s;
   logic               rf_we_s;
   logic [REG_AW-1:0]  rf_wa_s;
   logic [DATA_W-1:0]  rf_wd_s;
   logic [DATA_W-1:0]  mem_r [DEPTH];
   logic [DATA_W-1:0]  rdata_r;
   logic               mem_we_s;
   logic [DMEM_AW-1:0] mem_wa_s, mem_ra_s;
   logic [DATA_W-1:0]  mem_wd_s;
   logic [CNT_W-1:0]   blk_cnt_r, blk_cnt_s;
   logic [DMEM_AW-1:0] blk_src_r, blk_dst_r, blk_src_addr_s, blk_dst_addr_s;
   logic [4:0]         blk_op_r;
   logic               halted_r, halted_s, fault_r, fault_s;
   logic [1:0]         fault_code_r, fault_code_s;
   logic               ready_r, busy_r;
   logic [DATA_W-1:0]  result_r;
   logic [DATA_W-1:0]  key_s;
   logic [DATA_W-1:0]  alu_y_s;
   logic               alu_eq_s;

   assign opcode_s = instr_r[DATA_W-1 -: 5];
   assign r1_s     = instr_r[DATA_W-6 -: REG_AW];
   assign r2_s     = instr_r[DATA_W-6-REG_AW -: REG_AW];
   assign r3_s     = instr_r[DATA_W-6-2*REG_AW -: REG_AW];
   assign imm_s    = DATA_W'(instr_r[DATA_W-6:0]);
   assign ldi_s    = DATA_W'(instr_r[LDI_W-1:0]);
   assign v1_s     = rf_r[r1_s];
   assign v2_s     = rf_r[r2_s];
   assign v3_s     = rf_r[r3_s];
   assign pc_inc_s = pc_r + DATA_W'(1);
   assign sp_dec_s = sp_r - SP_W'(1);
   assign blk_src_addr_s = blk_src_r + DMEM_AW'(blk_cnt_r);
   assign blk_dst_addr_s = blk_dst_r + DMEM_AW'(blk_cnt_r);

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op    (opcode_s),
      .a     (v2_s),
      .b     (v3_s),
      .cmp_a (v1_s),
      .cmp_b (v2_s),
      .y     (alu_y_s),
      .eq    (alu_eq_s)
   );

`ifdef CPU_KEY_REG_EN
   logic [DATA_W-1:0] key_r;
   logic              key_we_s;

   // Block-op key register, loaded by SETKEY
   always_ff @(posedge clk) begin
      if (rst) begin
         key_r <= KEY_DEFAULT;
      end else if (key_we_s) begin
         key_r <= v2_s;
      end else begin
         key_r <= key_r;
      end
   end

   assign key_s = key_r;
`else
   assign key_s = KEY_DEFAULT;
`endif

   // Next-state, register-file, stack and memory control decode
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      sp_s         = sp_r;
      push_s       = 1'b0;
      rf_we_s      = 1'b0;
      rf_wa_s      = r1_s;
      rf_wd_s      = alu_y_s;
      mem_we_s     = 1'b0;
      mem_wa_s     = blk_dst_addr_s;
      mem_wd_s     = v1_s;
      mem_ra_s     = blk_src_addr_s;
      blk_cnt_s    = blk_cnt_r;
      halted_s     = halted_r;
      fault_s      = fault_r;
      fault_code_s = fault_code_r;
`ifdef CPU_KEY_REG_EN
      key_we_s     = 1'b0;
`endif
      case (state_r)
         ST_FETCH: begin
            if (instr_valid) state_s = ST_EXEC;
            else             state_s = ST_FETCH;
         end
         ST_EXEC: begin
            state_s = ST_FETCH;
            pc_s    = pc_inc_s;
            case (opcode_s)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL: rf_we_s = 1'b1;
               OP_LDI: begin
                  rf_we_s = 1'b1;
                  rf_wd_s = ldi_s;
               end
               OP_LD: begin
                  mem_ra_s = v2_s[DMEM_AW-1:0];
                  state_s  = ST_LDWAIT;
                  pc_s     = pc_r;
               end
               OP_ST: begin
                  mem_we_s = 1'b1;
                  mem_wa_s = v2_s[DMEM_AW-1:0];
               end
               OP_JMP: pc_s = imm_s;
               OP_JEQ: begin
                  if (alu_eq_s) pc_s = v3_s;
                  else          pc_s = pc_inc_s;
               end
               OP_JNE: begin
                  if (!alu_eq_s) pc_s = v3_s;
                  else           pc_s = pc_inc_s;
               end
               OP_CALL: begin
                  if (sp_r == SP_W'(STACK_DEPTH)) begin
                     state_s      = ST_FAULT;
                     pc_s         = pc_r;
                     fault_s      = 1'b1;
                     fault_code_s = FAULT_OVF;
                  end else begin
                     push_s = 1'b1;
                     sp_s   = sp_r + SP_W'(1);
                     pc_s   = imm_s;
                  end
               end
               OP_RET: begin
                  if (sp_r == {SP_W{1'b0}}) begin
                     state_s      = ST_FAULT;
                     pc_s         = pc_r;
                     fault_s      = 1'b1;
                     fault_code_s = FAULT_UDF;
                  end else begin
                     sp_s = sp_dec_s;
                     pc_s = stack_r[sp_dec_s[SIDX_W-1:0]];
                  end
               end
               OP_BINC, OP_BENC, OP_BDEC: begin
                  state_s   = ST_BLK_RD;
                  pc_s      = pc_r;
                  blk_cnt_s = {CNT_W{1'b0}};
               end
`ifdef CPU_KEY_REG_EN
               OP_SETKEY: key_we_s = 1'b1;
`endif
               OP_HALT: begin
                  state_s  = ST_HALT;
                  halted_s = 1'b1;
                  pc_s     = pc_r;
               end
               default: pc_s = pc_inc_s;
            endcase
         end
         ST_LDWAIT: begin
            rf_we_s = 1'b1;
            rf_wd_s = rdata_r;
            pc_s    = pc_inc_s;
            state_s = ST_FETCH;
         end
         ST_BLK_RD: state_s = ST_BLK_WR;
         ST_BLK_WR: begin
            mem_we_s = 1'b1;
            if (blk_op_r == OP_BINC) mem_wd_s = rdata_r + DATA_W'(1);
            else                     mem_wd_s = rdata_r ^ key_s;
            if (blk_cnt_r == CNT_W'(BLK_LEN - 1)) begin
               state_s = ST_FETCH;
               pc_s    = pc_inc_s;
            end else begin
               blk_cnt_s = blk_cnt_r + CNT_W'(1);
               state_s   = ST_BLK_RD;
            end
         end
         ST_HALT:  state_s = ST_HALT;
         ST_FAULT: state_s = ST_FAULT;
         default:  state_s = ST_FETCH;
      endcase
   end

   // Architectural state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_FETCH;
         pc_r         <= {DATA_W{1'b0}};
         sp_r         <= {SP_W{1'b0}};
         instr_r      <= {DATA_W{1'b0}};
         for (int i = 0; i < 2**REG_AW; i++) rf_r[i] <= {DATA_W{1'b0}};
         blk_cnt_r    <= {CNT_W{1'b0}};
         blk_src_r    <= {DMEM_AW{1'b0}};
         blk_dst_r    <= {DMEM_AW{1'b0}};
         blk_op_r     <= 5'h00;
         halted_r     <= 1'b0;
         fault_r      <= 1'b0;
         fault_code_r <= FAULT_NONE;
         ready_r      <= 1'b1;
         busy_r       <= 1'b0;
         result_r     <= {DATA_W{1'b0}};
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         sp_r         <= sp_s;
         blk_cnt_r    <= blk_cnt_s;
         halted_r     <= halted_s;
         fault_r      <= fault_s;
         fault_code_r <= fault_code_s;
         ready_r      <= (state_s == ST_FETCH);
         busy_r       <= (state_s != ST_FETCH);
         result_r     <= rf_r[0];
         if (state_r == ST_FETCH && instr_valid) instr_r <= instr;
         if (rf_we_s) rf_r[rf_wa_s] <= rf_wd_s;
         if (state_r == ST_EXEC) begin
            blk_src_r <= v2_s[DMEM_AW-1:0];
            blk_dst_r <= v1_s[DMEM_AW-1:0];
            blk_op_r  <= opcode_s;
         end
      end
   end

   // Un-reset storage: call stack and synchronous data memory
   always_ff @(posedge clk) begin
      if (push_s && !rst) stack_r[sp_r[SIDX_W-1:0]] <= pc_inc_s;
      if (mem_we_s && !rst) mem_r[mem_wa_s] <= mem_wd_s;
      rdata_r <= mem_r[mem_ra_s];
   end

   assign instr_ready = ready_r;
   assign pc          = pc_r;
   assign result      = result_r;
   assign busy        = busy_r;
   assign halted      = halted_r;
   assign fault       = fault_r;
   assign fault_code  = fault_code_r;

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed self-checking bench for cpu_core_mc; memory is observed through LD
// into r0 and the registered result port.
module tb_cpu_core_mc;

   localparam int             DW  = 19;
   localparam logic [DW-1:0]  KEY = 19'h1999F;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] pc;
   logic [DW-1:0] result;
   logic          busy;
   logic          halted;
   logic          fault;
   logic [1:0]    fault_code;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            ncyc;

   cpu_core_mc dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc          (pc),
      .result      (result),
      .busy        (busy),
      .halted      (halted),
      .fault       (fault),
      .fault_code  (fault_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rrr(input logic [4:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 2'b00};
   endfunction

   function automatic logic [DW-1:0] ldi(input logic [3:0] r, input int v);
      return {5'h07, r, 10'(v)};
   endfunction

   function automatic logic [DW-1:0] jimm(input logic [4:0] op, input int v);
      return {op, 14'(v)};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic issue(input logic [DW-1:0] w);
      int t = 0;
      while (!instr_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("fetch_ready", 32'(instr_ready), 32'd1);
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      chk("ready_low_exec", 32'(instr_ready), 32'd0);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("idle", 32'(busy), 32'd0);
   endtask

   task automatic run(input logic [DW-1:0] w);
      int n;
      issue(w);
      wait_idle(n);
      @(negedge clk);
   endtask

   task automatic store8(input int base);
      for (int i = 0; i < 8; i++) begin
         run(ldi(4'd1, i));
         run(ldi(4'd2, base + i));
         run(rrr(5'h09, 4'd1, 4'd2, 4'd0));
      end
   endtask

   task automatic check_word(input string tag, input int addr, input logic [DW-1:0] exp);
      run(ldi(4'd2, addr));
      run(rrr(5'h08, 4'd0, 4'd2, 4'd0));
      chk(tag, 32'(result), 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      instr = '0;
      do_reset();
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_fcode", 32'(fault_code), 32'd0);

      run(ldi(4'd1, 5));
      run(ldi(4'd2, 7));
      run(rrr(5'h00, 4'd0, 4'd1, 4'd2));
      chk("add", 32'(result), 32'd12);
      chk("add_pc", 32'(pc), 32'd3);
      run(rrr(5'h01, 4'd0, 4'd1, 4'd2));
      chk("sub_wrap", 32'(result), 32'h7FFFE);

      // BENC 100 -> 200, then BDEC 200 -> 300
      store8(100);
      run(ldi(4'd1, 200));
      run(ldi(4'd2, 100));
      issue(rrr(5'h10, 4'd1, 4'd2, 4'd0));
      wait_idle(ncyc);
      chk("benc_busy_cycles", 32'(ncyc), 32'd17);
      @(negedge clk);
      for (int i = 0; i < 8; i++) check_word("benc_word", 200 + i, DW'(i) ^ KEY);
      run(ldi(4'd1, 300));
      run(ldi(4'd2, 200));
      run(rrr(5'h11, 4'd1, 4'd2, 4'd0));
      for (int i = 0; i < 8; i++) check_word("bdec_word", 300 + i, DW'(i));

      do_reset();
      run(jimm(5'h0D, 40));
      chk("call_pc", 32'(pc), 32'd40);
      run(rrr(5'h0E, 4'd0, 4'd0, 4'd0));
      chk("ret_pc", 32'(pc), 32'd1);

      do_reset();
      issue(rrr(5'h0E, 4'd0, 4'd0, 4'd0));
      @(negedge clk);
      chk("udf_fault", 32'(fault), 32'd1);
      chk("udf_code", 32'(fault_code), 32'd2);
      chk("udf_pc", 32'(pc), 32'd0);

      do_reset();
      for (int i = 0; i < 16; i++) run(jimm(5'h0D, 10 + i));
      chk("calls16_pc", 32'(pc), 32'd25);
      chk("calls16_nofault", 32'(fault), 32'd0);
      issue(jimm(5'h0D, 99));
      @(negedge clk);
      chk("ovf_fault", 32'(fault), 32'd1);
      chk("ovf_code", 32'(fault_code), 32'd1);
      chk("ovf_pc", 32'(pc), 32'd25);
      instr = ldi(4'd0, 1);
      instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("fault_ready_low", 32'(instr_ready), 32'd0);
      end
      instr_valid = 1'b0;
      chk("fault_pc_hold", 32'(pc), 32'd25);

      do_reset();
      run(ldi(4'd0, 3));
      issue(rrr(5'h1F, 4'd0, 4'd0, 4'd0));
      @(negedge clk);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_pc", 32'(pc), 32'd1);
      chk("halt_busy", 32'(busy), 32'd1);

      // In-place BINC at 100, reset after three words are written
      do_reset();
      store8(100);
      run(ldi(4'd1, 100));
      run(ldi(4'd2, 100));
      issue(rrr(5'h0F, 4'd1, 4'd2, 4'd0));
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("binc_rst_pc", 32'(pc), 32'd0);
      chk("binc_rst_busy", 32'(busy), 32'd0);
      chk("binc_rst_ready", 32'(instr_ready), 32'd1);
      for (int i = 0; i < 8; i++)
         check_word("binc_abort_word", 100 + i, (i < 3) ? DW'(i + 1) : DW'(i));

`ifdef CPU_KEY_REG_EN
      do_reset();
      store8(100);
      run(ldi(4'd1, 8'hFF));
      run(rrr(5'h12, 4'd0, 4'd1, 4'd0));
      run(ldi(4'd1, 200));
      run(ldi(4'd2, 100));
      run(rrr(5'h10, 4'd1, 4'd2, 4'd0));
      for (int i = 0; i < 8; i++) check_word("setkey_word", 200 + i, DW'(i) ^ DW'(8'hFF));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
